// File: rtl/modrm_fetch_unit.sv
// ---------------------------------------------------------------------------
// modrm_fetch_unit
//
// Sequential ModRM / displacement / memory-operand fetcher for the x86 front
// end. The opcode stage pulses start in IDLE. The unit then takes one byte
// per clock from the 8-bit bus: the ModRM byte, an optional disp8/disp16, and
// the little-endian r/m memory operand. It returns both operands, the
// effective address, the effective segment and the IP after the last code
// byte it consumed.
//
// Optional feature macro: IMM_FETCH_EN
//   Defined   : if imm_req is set, an immediate is fetched from cs:ip after
//               the operand. It is either one sign-extended byte (imm_s8) or
//               n little-endian bytes. It is returned in op2, and op1 is then
//               the r/m operand.
//   Undefined : imm_req and imm_s8 have no effect and IMM is never entered.
//
// Parameters
//   ADDR_W : physical address width (address arithmetic wraps to it)
//   OPW    : register/operand width, 16 or 32
//
// Ports
//   clock, reset_n          : rising-edge clock, async active-low reset
//   start                   : fetch request, only honoured in IDLE
//   ip_in                   : IP of the ModRM byte
//   cs, ds, ss              : segment registers
//   override, seg_ovr       : segment prefix present / its segment value
//   regs                    : register file snapshot, AX..DI at index 0..7
//   size                    : 0 byte, 1 word, 2 dword
//   dir                     : 0 -> op1=r/m, op2=reg ; 1 -> op1=reg, op2=r/m
//   imm_req, imm_s8         : immediate request / immediate is one sext byte
//   address                 : bus address, combinational from state
//   data                    : bus read data, valid in the same cycle
//   busy, done              : fetch in progress / one-cycle completion pulse
//   modrm, is_reg           : latched ModRM byte / mod==11
//   ea, seg                 : effective address / effective segment
//   ip_out                  : IP after the last consumed code byte
//   op1, op2                : operands, zero-extended to OPW
// ---------------------------------------------------------------------------
module modrm_fetch_unit #(
    parameter int ADDR_W = 20,
    parameter int OPW    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       ip_in,
    input  logic [15:0]       cs,
    input  logic [15:0]       ds,
    input  logic [15:0]       ss,
    input  logic              override,
    input  logic [15:0]       seg_ovr,
    input  logic [8*OPW-1:0]  regs,
    input  logic [1:0]        size,
    input  logic              dir,
    input  logic              imm_req,
    input  logic              imm_s8,
    output logic [ADDR_W-1:0] address,
    input  logic [7:0]        data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        modrm,
    output logic              is_reg,
    output logic [15:0]       ea,
    output logic [15:0]       seg,
    output logic [15:0]       ip_out,
    output logic [OPW-1:0]    op1,
    output logic [OPW-1:0]    op2
);

    // Physical address is computed wide enough to hold seg*16 + offset
    // without losing the carry, then truncated to ADDR_W.
    localparam int PW = (ADDR_W > 20) ? ADDR_W : 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MODRM   = 3'd1,
        ST_DISP_LO = 3'd2,
        ST_DISP_HI = 3'd3,
        ST_MEM     = 3'd4,
        ST_IMM     = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] s,
                                                    input logic [15:0] off);
        logic [PW-1:0] sum;
        sum = PW'({s, 4'h0}) + PW'(off);
        return sum[ADDR_W-1:0];
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        logic [31:0] m;
        case (sz)
            2'd0:    m = 32'h0000_00FF;
            2'd1:    m = 32'h0000_FFFF;
            2'd2:    m = 32'hFFFF_FFFF;
            default: m = 32'h0000_FFFF;
        endcase
        return m;
    endfunction

    // Index of the last operand byte (n-1) for a given size.
    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        logic [1:0] l;
        case (sz)
            2'd0:    l = 2'd0;
            2'd1:    l = 2'd1;
            2'd2:    l = 2'd3;
            default: l = 2'd1;
        endcase
        return l;
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Register operand. In byte mode idx[1:0] picks AX..BX and idx[2]
    // picks the high byte. The result is zero-extended.
    function automatic logic [31:0] reg_operand(input logic [8*OPW-1:0] rf,
                                                input logic [2:0]       idx,
                                                input logic [1:0]       sz);
        logic [2:0]     ri;
        logic [OPW-1:0] word;
        logic [31:0]    full;
        ri   = (sz == 2'd0) ? {1'b0, idx[1:0]} : idx;
        word = rf[OPW-1:0];
        for (int i = 0; i < 8; i++) begin
            if (ri == 3'(i)) begin
                word = rf[i*OPW +: OPW];
            end
        end
        if (sz == 2'd0) begin
            full = {24'h000000, (idx[2] ? word[15:8] : word[7:0])};
        end else begin
            full = 32'(word) & size_mask(sz);
        end
        return full;
    endfunction

    // 16-bit base of the effective address. rm=110 with mod=00 is the
    // direct-address form, where the displacement alone forms the EA.
    function automatic logic [15:0] ea_base(input logic [8*OPW-1:0] rf,
                                            input logic [7:0]       m);
        logic [15:0] bx, bp, si, di, b;
        bx = rf[3*OPW +: 16];
        bp = rf[5*OPW +: 16];
        si = rf[6*OPW +: 16];
        di = rf[7*OPW +: 16];
        case (m[2:0])
            3'b000:  b = bx + si;
            3'b001:  b = bx + di;
            3'b010:  b = bp + si;
            3'b011:  b = bp + di;
            3'b100:  b = si;
            3'b101:  b = di;
            3'b110:  b = (m[7:6] == 2'b00) ? 16'h0000 : bp;
            default: b = bx;
        endcase
        return b;
    endfunction

    // Default segment is SS whenever BP takes part in the address.
    function automatic logic [15:0] seg_select(input logic [7:0]  m,
                                               input logic        ovr,
                                               input logic [15:0] sovr,
                                               input logic [15:0] d,
                                               input logic [15:0] s);
        logic [15:0] r;
        if (ovr) begin
            r = sovr;
        end else if ((m[7:6] != 2'b11) && (m[2:1] == 2'b01)) begin
            r = s;
        end else if ((m[2:0] == 3'b110) &&
                     ((m[7:6] == 2'b01) || (m[7:6] == 2'b10))) begin
            r = s;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t          state_r, state_next_s;
    logic [15:0]     ip_r;
    logic [1:0]      k_r;
    logic [1:0]      size_r;
    logic            dir_r, imm_req_r, imm_s8_r;
    logic [15:0]     cs_r, ds_r, ss_r, seg_ovr_r;
    logic            ovr_r;
    logic [7:0]      modrm_r;
    logic            is_reg_r;
    logic [15:0]     ea_r, seg_r, ip_out_r;
    logic [OPW-1:0]  op1_r, op2_r;
    logic            busy_r, done_r;
    logic [OPW-1:0]  rm_acc_r, imm_acc_r;

    logic [7:0]      modrm_cur_s;
    logic            mod11_s;
    logic            k_last_s;
    logic            imm_last_s;
    logic            imm_go_s;
    logic [15:0]     ip_inc_s;
    logic            code_byte_s;
    logic [OPW-1:0]  rm_next_s, imm_next_s;
    logic [OPW-1:0]  rm_final_s, imm_final_s, reg_op_s;

`ifdef IMM_FETCH_EN
    assign imm_go_s = imm_req_r;
`else
    logic unused_imm_s;
    assign imm_go_s     = 1'b0;
    assign unused_imm_s = imm_req_r;
`endif

    assign ip_inc_s   = ip_r + 16'd1;
    assign k_last_s   = (k_r == last_idx(size_r));
    assign imm_last_s = imm_s8_r | k_last_s;

    // ModRM is still on the bus while in MODRM, so decode from data there.
    always_comb begin
        modrm_cur_s = modrm_r;
        if (state_r == ST_MODRM) begin
            modrm_cur_s = data;
        end else begin
            modrm_cur_s = modrm_r;
        end
        mod11_s = (modrm_cur_s[7:6] == 2'b11);
    end

    // Code bytes advance ip; operand bytes do not.
    always_comb begin
        code_byte_s = 1'b0;
        case (state_r)
            ST_MODRM, ST_DISP_LO, ST_DISP_HI, ST_IMM: code_byte_s = 1'b1;
            default:                                  code_byte_s = 1'b0;
        endcase
    end

    // Little-endian byte insertion for the r/m and immediate accumulators.
    always_comb begin
        rm_next_s  = rm_acc_r;
        imm_next_s = imm_acc_r;
        for (int b = 0; b < OPW/8; b++) begin
            if (k_r == 2'(b)) begin
                rm_next_s[b*8 +: 8]  = data;
                imm_next_s[b*8 +: 8] = data;
            end else begin
                rm_next_s[b*8 +: 8]  = rm_acc_r[b*8 +: 8];
                imm_next_s[b*8 +: 8] = imm_acc_r[b*8 +: 8];
            end
        end
    end

    // Final operand values. They are valid on the edge that enters DONE.
    always_comb begin
        reg_op_s = OPW'(reg_operand(regs, modrm_cur_s[5:3], size_r));
        if (mod11_s) begin
            rm_final_s = OPW'(reg_operand(regs, modrm_cur_s[2:0], size_r));
        end else if (state_r == ST_MEM) begin
            rm_final_s = rm_next_s;
        end else begin
            rm_final_s = rm_acc_r;
        end
        if (imm_s8_r) begin
            imm_final_s = OPW'(sext8(data) & size_mask(size_r));
        end else begin
            imm_final_s = imm_next_s;
        end
    end

    // Bus address: operand fetch in MEM, otherwise the code stream cs:ip.
    always_comb begin
        address = {ADDR_W{1'b0}};
        case (state_r)
            ST_MEM:  address = phys_addr(seg_r, ea_r + {14'h0000, k_r});
            ST_IDLE: address = phys_addr(cs, ip_r);
            default: address = phys_addr(cs_r, ip_r);
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_MODRM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MODRM: begin
                if (data[7:6] == 2'b11) begin
                    state_next_s = imm_go_s ? ST_IMM : ST_DONE;
                end else if ((data[7:6] == 2'b00) && (data[2:0] != 3'b110)) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_DISP_LO;
                end
            end
            ST_DISP_LO: begin
                if (modrm_r[7:6] == 2'b01) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_DISP_HI;
                end
            end
            ST_DISP_HI: state_next_s = ST_MEM;
            ST_MEM: begin
                if (k_last_s) begin
                    state_next_s = imm_go_s ? ST_IMM : ST_DONE;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_IMM: begin
                if (imm_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IMM;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request latch, ModRM decode, displacement accumulation and byte counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ip_r      <= 16'h0000;
            k_r       <= 2'd0;
            size_r    <= 2'd0;
            dir_r     <= 1'b0;
            imm_req_r <= 1'b0;
            imm_s8_r  <= 1'b0;
            cs_r      <= 16'h0000;
            ds_r      <= 16'h0000;
            ss_r      <= 16'h0000;
            ovr_r     <= 1'b0;
            seg_ovr_r <= 16'h0000;
            modrm_r   <= 8'h00;
            is_reg_r  <= 1'b0;
            ea_r      <= 16'h0000;
            seg_r     <= 16'h0000;
            rm_acc_r  <= {OPW{1'b0}};
            imm_acc_r <= {OPW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ip_r      <= ip_in;
                        size_r    <= size;
                        dir_r     <= dir;
                        imm_req_r <= imm_req;
                        imm_s8_r  <= imm_s8;
                        cs_r      <= cs;
                        ds_r      <= ds;
                        ss_r      <= ss;
                        ovr_r     <= override;
                        seg_ovr_r <= seg_ovr;
                    end
                end
                ST_MODRM: begin
                    modrm_r   <= data;
                    is_reg_r  <= (data[7:6] == 2'b11);
                    ea_r      <= ea_base(regs, data);
                    seg_r     <= seg_select(data, ovr_r, seg_ovr_r, ds_r, ss_r);
                    ip_r      <= ip_inc_s;
                    k_r       <= 2'd0;
                    rm_acc_r  <= {OPW{1'b0}};
                    imm_acc_r <= {OPW{1'b0}};
                end
                ST_DISP_LO: begin
                    ip_r <= ip_inc_s;
                    if (modrm_r[7:6] == 2'b01) begin
                        ea_r <= ea_r + {{8{data[7]}}, data};
                    end else begin
                        ea_r <= ea_r + {8'h00, data};
                    end
                end
                ST_DISP_HI: begin
                    ip_r <= ip_inc_s;
                    ea_r <= ea_r + {data, 8'h00};
                end
                ST_MEM: begin
                    rm_acc_r <= rm_next_s;
                    k_r      <= k_last_s ? 2'd0 : (k_r + 2'd1);
                end
                ST_IMM: begin
                    ip_r      <= ip_inc_s;
                    imm_acc_r <= imm_next_s;
                    k_r       <= k_r + 2'd1;
                end
                default: begin
                    k_r <= 2'd0;
                end
            endcase
        end
    end

    // busy/done are registered from the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // Results are captured on the edge into DONE and held until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ip_out_r <= 16'h0000;
            op1_r    <= {OPW{1'b0}};
            op2_r    <= {OPW{1'b0}};
        end else if (state_next_s == ST_DONE) begin
            ip_out_r <= code_byte_s ? ip_inc_s : ip_r;
            if (state_r == ST_IMM) begin
                op1_r <= rm_final_s;
                op2_r <= imm_final_s;
            end else if (dir_r) begin
                op1_r <= reg_op_s;
                op2_r <= rm_final_s;
            end else begin
                op1_r <= rm_final_s;
                op2_r <= reg_op_s;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign modrm  = modrm_r;
    assign is_reg = is_reg_r;
    assign ea     = ea_r;
    assign seg    = seg_r;
    assign ip_out = ip_out_r;
    assign op1    = op1_r;
    assign op2    = op2_r;

endmodule

// File: tb/tb_modrm_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_modrm_fetch_unit
//
// Directed bench for modrm_fetch_unit (ADDR_W=20, OPW=16). A byte-wide
// memory model answers the bus combinationally. Each accepted request
// pushes its expected result to a scoreboard queue. The entry is popped and
// compared when the done pulse appears.
// ---------------------------------------------------------------------------
module tb_modrm_fetch_unit;

    localparam int AW = 20;
    localparam int W  = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [15:0]   ip_in, cs, ds, ss, seg_ovr;
    logic          override;
    logic [8*W-1:0] regs;
    logic [1:0]    size;
    logic          dir, imm_req, imm_s8;
    logic [AW-1:0] address;
    logic [7:0]    data;
    logic          busy, done, is_reg;
    logic [7:0]    modrm;
    logic [15:0]   ea, seg, ip_out;
    logic [W-1:0]  op1, op2;

    logic [7:0] mem [0:1048575];

    typedef struct {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] ea;
        logic [15:0] seg;
        logic [15:0] ip_out;
        logic [7:0]  modrm;
        logic        is_reg;
        int          cyc;
        bit          chk_ea;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int accepted = 0;

    always #5 clock = ~clock;

    assign data = mem[address];

    always @(posedge clock) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    modrm_fetch_unit #(.ADDR_W(AW), .OPW(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .ip_in(ip_in),
        .cs(cs), .ds(ds), .ss(ss), .override(override), .seg_ovr(seg_ovr),
        .regs(regs), .size(size), .dir(dir), .imm_req(imm_req),
        .imm_s8(imm_s8), .address(address), .data(data), .busy(busy),
        .done(done), .modrm(modrm), .is_reg(is_reg), .ea(ea), .seg(seg),
        .ip_out(ip_out), .op1(op1), .op2(op2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_reg(input int i, input logic [15:0] v);
        regs[i*16 +: 16] = v;
    endtask

    // Issue one request (called at a negedge), wait for done, score it.
    task automatic run_op(input string tag, input exp_t e, input logic pulse_busy);
        exp_t x;
        int   cyc;
        sb.push_back(e);
        accepted++;
        start = 1'b1;
        @(posedge clock); @(negedge clock);
        start = pulse_busy;
        cyc = 1;
        chk({tag, ".busy_c1"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clock); @(negedge clock);
            start = 1'b0;
            cyc++;
        end
        start = 1'b0;
        x = sb.pop_front();
        chk({tag, ".done"},   {31'd0, done},   32'd1);
        chk({tag, ".cycle"},  cyc,             x.cyc);
        chk({tag, ".busy_d"}, {31'd0, busy},   32'd0);
        chk({tag, ".op1"},    {16'd0, op1},    {16'd0, x.op1});
        chk({tag, ".op2"},    {16'd0, op2},    {16'd0, x.op2});
        chk({tag, ".seg"},    {16'd0, seg},    {16'd0, x.seg});
        chk({tag, ".ip_out"}, {16'd0, ip_out}, {16'd0, x.ip_out});
        chk({tag, ".modrm"},  {24'd0, modrm},  {24'd0, x.modrm});
        chk({tag, ".is_reg"}, {31'd0, is_reg}, {31'd0, x.is_reg});
        if (x.chk_ea) chk({tag, ".ea"}, {16'd0, ea}, {16'd0, x.ea});
        @(posedge clock); @(negedge clock);
        chk({tag, ".done_1cyc"}, {31'd0, done}, 32'd0);
        chk({tag, ".op1_hold"},  {16'd0, op1},  {16'd0, x.op1});
    endtask

    initial begin
        exp_t e;
        int   snap;
        for (int i = 0; i < 1048576; i++) mem[i] = 8'h00;
        reset_n = 1'b0; start = 1'b0; ip_in = 16'h0000;
        cs = 16'hF000; ds = 16'h1000; ss = 16'h2000;
        override = 1'b0; seg_ovr = 16'h3000; regs = '0;
        size = 2'd1; dir = 1'b0; imm_req = 1'b0; imm_s8 = 1'b0;
        set_reg(0, 16'h1234); set_reg(1, 16'h4321); set_reg(2, 16'h5555);
        set_reg(3, 16'h00FF); set_reg(5, 16'h0010); set_reg(6, 16'h0101);
        mem[20'hF0100] = 8'hD8;
        mem[20'hF0200] = 8'hE0;
        mem[20'hF0300] = 8'h06; mem[20'hF0301] = 8'hFF; mem[20'hF0302] = 8'hFF;
        mem[20'h1FFFF] = 8'h34; mem[20'h10000] = 8'h12;
        mem[20'hF0400] = 8'h46; mem[20'hF0401] = 8'hFE;
        mem[20'h2000E] = 8'h77; mem[20'h3000E] = 8'h66;
        mem[20'hF0500] = 8'h10; mem[20'h10200] = 8'hCD; mem[20'h10201] = 8'hAB;
        mem[20'hF0600] = 8'hC1; mem[20'hF0601] = 8'h80;

        // Reset state.
        #12;
        chk("rst.busy",   {31'd0, busy},   32'd0);
        chk("rst.done",   {31'd0, done},   32'd0);
        chk("rst.modrm",  {24'd0, modrm},  32'd0);
        chk("rst.is_reg", {31'd0, is_reg}, 32'd0);
        chk("rst.ea",     {16'd0, ea},     32'd0);
        chk("rst.seg",    {16'd0, seg},    32'd0);
        chk("rst.ip_out", {16'd0, ip_out}, 32'd0);
        chk("rst.op1",    {16'd0, op1},    32'd0);
        chk("rst.op2",    {16'd0, op2},    32'd0);
        chk("rst.address", {12'd0, address}, 32'h000F0000);
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);

        // Register mode, word.
        ip_in = 16'h0100; size = 2'd1; dir = 1'b0;
        e = '{op1:16'h1234, op2:16'h00FF, ea:16'h0, seg:16'h1000, ip_out:16'h0101,
              modrm:8'hD8, is_reg:1'b1, cyc:2, chk_ea:1'b0};
        run_op("regw", e, 1'b0);

        // Register mode, byte, dir=1.
        set_reg(0, 16'hA55A);
        ip_in = 16'h0200; size = 2'd0; dir = 1'b1;
        e = '{op1:16'h00A5, op2:16'h005A, ea:16'h0, seg:16'h1000, ip_out:16'h0201,
              modrm:8'hE0, is_reg:1'b1, cyc:2, chk_ea:1'b0};
        run_op("regb", e, 1'b0);

        // Direct disp16 with offset wrap inside the segment.
        ip_in = 16'h0300; size = 2'd1; dir = 1'b0;
        e = '{op1:16'h1234, op2:16'hA55A, ea:16'hFFFF, seg:16'h1000, ip_out:16'h0303,
              modrm:8'h06, is_reg:1'b0, cyc:6, chk_ea:1'b1};
        run_op("disp16", e, 1'b0);

        // BP+disp8 defaults to SS.
        ip_in = 16'h0400; size = 2'd0; dir = 1'b0;
        e = '{op1:16'h0077, op2:16'h005A, ea:16'h000E, seg:16'h2000, ip_out:16'h0402,
              modrm:8'h46, is_reg:1'b0, cyc:4, chk_ea:1'b1};
        run_op("bp_ss", e, 1'b0);

        // Same with a segment override.
        override = 1'b1;
        e = '{op1:16'h0066, op2:16'h005A, ea:16'h000E, seg:16'h3000, ip_out:16'h0402,
              modrm:8'h46, is_reg:1'b0, cyc:4, chk_ea:1'b1};
        run_op("bp_ovr", e, 1'b0);
        override = 1'b0;

        // mod=00 BX+SI word, dir=1; an extra start while busy is ignored.
        ip_in = 16'h0500; size = 2'd1; dir = 1'b1;
        e = '{op1:16'h5555, op2:16'hABCD, ea:16'h0200, seg:16'h1000, ip_out:16'h0501,
              modrm:8'h10, is_reg:1'b0, cyc:4, chk_ea:1'b1};
        run_op("bxsi", e, 1'b1);

        // Immediate request.
        ip_in = 16'h0600; size = 2'd1; dir = 1'b0; imm_req = 1'b1; imm_s8 = 1'b1;
`ifdef IMM_FETCH_EN
        e = '{op1:16'h4321, op2:16'hFF80, ea:16'h0, seg:16'h1000, ip_out:16'h0602,
              modrm:8'hC1, is_reg:1'b1, cyc:3, chk_ea:1'b0};
`else
        e = '{op1:16'h4321, op2:16'hA55A, ea:16'h0, seg:16'h1000, ip_out:16'h0601,
              modrm:8'hC1, is_reg:1'b1, cyc:2, chk_ea:1'b0};
`endif
        run_op("imm", e, 1'b0);
        imm_req = 1'b0; imm_s8 = 1'b0;

        // Reset while in MEM: outputs clear, no done pulse.
        ip_in = 16'h0300; size = 2'd1; dir = 1'b0;
        snap = done_cnt;
        start = 1'b1;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        repeat (3) begin @(posedge clock); @(negedge clock); end
        chk("abort.busy_mem", {31'd0, busy}, 32'd1);
        chk("abort.addr_mem", {12'd0, address}, 32'h0001FFFF);
        reset_n = 1'b0;
        #1;
        chk("abort.busy",   {31'd0, busy},   32'd0);
        chk("abort.done",   {31'd0, done},   32'd0);
        chk("abort.modrm",  {24'd0, modrm},  32'd0);
        chk("abort.ea",     {16'd0, ea},     32'd0);
        chk("abort.seg",    {16'd0, seg},    32'd0);
        chk("abort.ip_out", {16'd0, ip_out}, 32'd0);
        chk("abort.op1",    {16'd0, op1},    32'd0);
        chk("abort.op2",    {16'd0, op2},    32'd0);
        @(negedge clock); reset_n = 1'b1;
        repeat (8) @(negedge clock);
        chk("abort.no_done", done_cnt, snap);

        // Recovery after the abort.
        ip_in = 16'h0100; size = 2'd1; dir = 1'b0;
        e = '{op1:16'hA55A, op2:16'h00FF, ea:16'h0, seg:16'h1000, ip_out:16'h0101,
              modrm:8'hD8, is_reg:1'b1, cyc:2, chk_ea:1'b0};
        run_op("recover", e, 1'b0);

        repeat (4) @(negedge clock);
        chk("done_count", done_cnt, accepted);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
